hpm_counter_bank: RTL and testbench

- Multi-channel event counter bank; parametrised successor to the single-channel counter.
- Each channel holds a WIDTH-bit counter that advances by a per-cycle event increment (0..2^INC_W-1). Channels can be inhibited individually.
- Counters are read and written through one XLEN-wide port with lo/hi halves, and each channel has a sticky overflow flag.
- Sits beside the CSR file and feeds mhpmcounter/mcountinhibit-style registers.

---
 rtl/hpm_pkg.sv | 8 +
 rtl/hpm_channel.sv | 42 ++++
 rtl/hpm_counter_bank.sv | 54 +++++
 tb/tb_hpm_counter_bank.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/hpm_pkg.sv
// hpm_pkg: shared constants and helpers for the hpm counter bank
package hpm_pkg;
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/hpm_channel.sv
// hpm_channel: one event counter with split lo/hi write and sticky overflow flag
// Overflow flops exist only when HPM_OVF_IRQ_EN is defined.
module hpm_channel #(
  parameter int WIDTH = 64,
  parameter int XLEN  = 32,
  parameter int INC_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [XLEN-1:0]  wd,
  input  logic [INC_W-1:0] inc,
  input  logic             count_en,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] cnt,
  output logic             ovf
);
  localparam int EW = 2 * XLEN;
  localparam int SW = (WIDTH > INC_W ? WIDTH : INC_W) + 1;
  logic [EW-1:0] ext, wval;
  logic [SW-1:0] sum;
  logic          carry;
  // writes merge into a full 2*XLEN view, then truncate so bits >= WIDTH vanish
  assign ext   = EW'(cnt);
  assign wval  = wr_lo ? {ext[EW-1:XLEN], wd} : {wd, ext[XLEN-1:0]};
  assign sum   = SW'(cnt) + SW'(inc);
  assign carry = |sum[SW-1:WIDTH];
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (wr_lo || wr_hi) cnt <= wval[WIDTH-1:0];
    else if (count_en) cnt <= sum[WIDTH-1:0];
`ifdef HPM_OVF_IRQ_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) ovf <= 1'b0;
    else ovf <= (count_en && !(wr_lo || wr_hi) && carry) || (ovf && !ovf_clr);
`else
  logic unused;
  assign unused = ovf_clr ^ carry;
  assign ovf    = 1'b0;
`endif
endmodule

// File: rtl/hpm_counter_bank.sv
// hpm_counter_bank: multi-channel event counters with inhibit mask, lo/hi access port and overflow irq
// Overflow flags and irq are generated only when HPM_OVF_IRQ_EN is defined.
module hpm_counter_bank
  import hpm_pkg::*;
#(
  parameter int  CHANNELS = 4,
  parameter int  WIDTH    = 64,
  parameter int  XLEN     = 32,
  parameter int  INC_W    = 2,
  localparam int SEL_W    = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*INC_W-1:0] event_inc,
  input  logic                      inhibit_we,
  input  logic [CHANNELS-1:0]       inhibit_wd,
  output logic [CHANNELS-1:0]       inhibit,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      half,
  input  logic                      we,
  input  logic [XLEN-1:0]           wd,
  output logic [XLEN-1:0]           rd,
  output logic [CHANNELS-1:0]       ovf,
  input  logic [CHANNELS-1:0]       ovf_clr,
  output logic                      irq
);
  logic [WIDTH-1:0]  cnt [CHANNELS];
  logic [2*XLEN-1:0] val;
  always_ff @(posedge clk or negedge reset)
    if (!reset) inhibit <= '0;
    else if (inhibit_we) inhibit <= inhibit_wd;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    hpm_channel #(.WIDTH(WIDTH), .XLEN(XLEN), .INC_W(INC_W)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .wr_lo    (we && sel == SEL_W'(i) && half == HALF_LO),
      .wr_hi    (we && sel == SEL_W'(i) && half == HALF_HI),
      .wd       (wd),
      .inc      (event_inc[i*INC_W +: INC_W]),
      .count_en (!inhibit[i]),
      .ovf_clr  (ovf_clr[i]),
      .cnt      (cnt[i]),
      .ovf      (ovf[i])
    );
  end
  // out-of-range sel matches no channel and reads as zero
  always_comb begin
    val = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (sel == SEL_W'(i)) val = (2*XLEN)'(cnt[i]);
  end
  assign rd  = half == HALF_HI ? val[2*XLEN-1:XLEN] : val[XLEN-1:0];
  assign irq = |ovf;
endmodule

// File: tb/tb_hpm_counter_bank.sv
// tb_hpm_counter_bank: scoreboard bench for hpm_counter_bank (4-channel and 3-channel instances)
module tb_hpm_counter_bank;
`ifdef HPM_OVF_IRQ_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif
  logic        clk = 1'b0, reset = 1'b0;
  logic [7:0]  event_inc = '0;
  logic        inhibit_we = 1'b0;
  logic [3:0]  inhibit_wd = '0, ovf_clr = '0;
  logic [3:0]  inhibit, ovf;
  logic [2:0]  inhibit3, ovf3;
  logic [1:0]  sel = '0;
  logic        half = 1'b0, we = 1'b0;
  logic [31:0] wd = '0, rd, rd3;
  logic        irq, irq3;
  int errors = 0, checks = 0;
  typedef struct {bit d3; int ch; bit hf; logic [31:0] v; string nm;} exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  hpm_counter_bank dut (
    .clk(clk), .reset(reset), .event_inc(event_inc), .inhibit_we(inhibit_we),
    .inhibit_wd(inhibit_wd), .inhibit(inhibit), .sel(sel), .half(half), .we(we),
    .wd(wd), .rd(rd), .ovf(ovf), .ovf_clr(ovf_clr), .irq(irq));

  hpm_counter_bank #(.CHANNELS(3)) dut3 (
    .clk(clk), .reset(reset), .event_inc(event_inc[5:0]), .inhibit_we(inhibit_we),
    .inhibit_wd(inhibit_wd[2:0]), .inhibit(inhibit3), .sel(sel), .half(half), .we(we),
    .wd(wd), .rd(rd3), .ovf(ovf3), .ovf_clr(ovf_clr[2:0]), .irq(irq3));

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input bit d3, input int ch, input bit hf, input logic [31:0] v, input string nm);
    q.push_back('{d3, ch, hf, v, nm});
  endtask

  task automatic wr(input int ch, input bit hf, input logic [31:0] v);
    we = 1'b1; sel = ch[1:0]; half = hf; wd = v;
    cyc(1);
    we = 1'b0;
  endtask

  task automatic test_reset;
    exp_t e;
    reset = 1'b0; event_inc = '1;
    cyc(3);
    checks++; if (ovf !== 4'b0) begin errors++; $display("FAIL reset_ovf: ovf=%b expected 0000", ovf); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: irq=%b expected 0", irq); end
    checks++; if (inhibit !== 4'b0) begin errors++; $display("FAIL reset_inhibit: inhibit=%b expected 0000", inhibit); end
    for (int c = 0; c < 4; c++) begin
      push(0, c, 0, 32'h0, "reset_lo");
      push(0, c, 1, 32'h0, "reset_hi");
    end
    while (q.size() > 0) begin
      e = q.pop_front(); @(negedge clk); sel = e.ch[1:0]; half = e.hf; #1; checks++;
      if ((e.d3 ? rd3 : rd) !== e.v) begin errors++; $display("FAIL %s ch%0d: rd=%h expected %h", e.nm, e.ch, e.d3 ? rd3 : rd, e.v); end
    end
    @(negedge clk); event_inc = 8'h01; reset = 1'b1;
    cyc(5);
    event_inc = '0;
    push(0, 0, 0, 32'd5, "count5_lo");
    push(0, 0, 1, 32'd0, "count5_hi");
    push(0, 1, 0, 32'd0, "count5_ch1");
    while (q.size() > 0) begin
      e = q.pop_front(); @(negedge clk); sel = e.ch[1:0]; half = e.hf; #1; checks++;
      if ((e.d3 ? rd3 : rd) !== e.v) begin errors++; $display("FAIL %s ch%0d: rd=%h expected %h", e.nm, e.ch, e.d3 ? rd3 : rd, e.v); end
    end
  endtask

  task automatic test_split_write;
    exp_t e;
    @(negedge clk);
    wr(2, 0, 32'hFFFF_FFFF);
    wr(2, 1, 32'h0000_0001);
    push(0, 2, 0, 32'hFFFF_FFFF, "split_lo");
    push(0, 2, 1, 32'h0000_0001, "split_hi");
    while (q.size() > 0) begin
      e = q.pop_front(); @(negedge clk); sel = e.ch[1:0]; half = e.hf; #1; checks++;
      if ((e.d3 ? rd3 : rd) !== e.v) begin errors++; $display("FAIL %s ch%0d: rd=%h expected %h", e.nm, e.ch, e.d3 ? rd3 : rd, e.v); end
    end
    @(negedge clk); event_inc = 8'b0001_0000;
    cyc(1);
    event_inc = '0;
    push(0, 2, 0, 32'h0, "carry_lo");
    push(0, 2, 1, 32'h2, "carry_hi");
    push(0, 0, 0, 32'd5, "carry_ch0_untouched");
    while (q.size() > 0) begin
      e = q.pop_front(); @(negedge clk); sel = e.ch[1:0]; half = e.hf; #1; checks++;
      if ((e.d3 ? rd3 : rd) !== e.v) begin errors++; $display("FAIL %s ch%0d: rd=%h expected %h", e.nm, e.ch, e.d3 ? rd3 : rd, e.v); end
    end
    checks++; if (ovf[2] !== 1'b0) begin errors++; $display("FAIL carry_ovf2: ovf=%b expected bit2=0", ovf); end
  endtask

  task automatic test_wrap;
    exp_t e;
    @(negedge clk);
    wr(1, 0, 32'hFFFF_FFFE);
    wr(1, 1, 32'hFFFF_FFFF);
    event_inc = 8'b0000_1100;
    cyc(1);
    event_inc = '0;
    push(0, 1, 0, 32'h1, "wrap_lo");
    push(0, 1, 1, 32'h0, "wrap_hi");
    while (q.size() > 0) begin
      e = q.pop_front(); @(negedge clk); sel = e.ch[1:0]; half = e.hf; #1; checks++;
      if ((e.d3 ? rd3 : rd) !== e.v) begin errors++; $display("FAIL %s ch%0d: rd=%h expected %h", e.nm, e.ch, e.d3 ? rd3 : rd, e.v); end
    end
    checks++; if (ovf !== {2'b00, OVF_EN, 1'b0}) begin errors++; $display("FAIL wrap_ovf: ovf=%b expected %b", ovf, {2'b00, OVF_EN, 1'b0}); end
    checks++; if (irq !== OVF_EN) begin errors++; $display("FAIL wrap_irq: irq=%b expected %b", irq, OVF_EN); end
  endtask

  task automatic test_set_beats_clear;
    exp_t e;
    @(negedge clk);
    wr(1, 0, 32'hFFFF_FFFF);
    wr(1, 1, 32'hFFFF_FFFF);
    checks++; if (ovf[1] !== OVF_EN) begin errors++; $display("FAIL write_keeps_ovf: ovf=%b expected bit1=%b", ovf, OVF_EN); end
    event_inc = 8'b0000_0100; ovf_clr = 4'b0010;
    cyc(1);
    event_inc = '0; ovf_clr = '0;
    push(0, 1, 0, 32'h0, "setclr_lo");
    push(0, 1, 1, 32'h0, "setclr_hi");
    while (q.size() > 0) begin
      e = q.pop_front(); @(negedge clk); sel = e.ch[1:0]; half = e.hf; #1; checks++;
      if ((e.d3 ? rd3 : rd) !== e.v) begin errors++; $display("FAIL %s ch%0d: rd=%h expected %h", e.nm, e.ch, e.d3 ? rd3 : rd, e.v); end
    end
    checks++; if (ovf[1] !== OVF_EN) begin errors++; $display("FAIL set_beats_clear: ovf=%b expected bit1=%b", ovf, OVF_EN); end
    @(negedge clk); ovf_clr = 4'b0010;
    cyc(1);
    ovf_clr = '0;
    checks++; if (ovf !== 4'b0) begin errors++; $display("FAIL clear_ovf: ovf=%b expected 0000", ovf); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL clear_irq: irq=%b expected 0", irq); end
  endtask

  task automatic test_inhibit;
    exp_t e;
    @(negedge clk);
    event_inc = 8'b0100_0000; inhibit_we = 1'b1; inhibit_wd = 4'b1000;
    cyc(1);
    inhibit_we = 1'b0;
    checks++; if (inhibit !== 4'b1000) begin errors++; $display("FAIL inhibit_mask: inhibit=%b expected 1000", inhibit); end
    cyc(3);
    push(0, 3, 0, 32'h1, "inhibit_hold");
    while (q.size() > 0) begin
      e = q.pop_front(); @(negedge clk); sel = e.ch[1:0]; half = e.hf; #1; checks++;
      if ((e.d3 ? rd3 : rd) !== e.v) begin errors++; $display("FAIL %s ch%0d: rd=%h expected %h", e.nm, e.ch, e.d3 ? rd3 : rd, e.v); end
    end
    @(negedge clk);
    wr(3, 0, 32'h10);
    push(0, 3, 0, 32'h10, "inhibit_write");
    while (q.size() > 0) begin
      e = q.pop_front(); @(negedge clk); sel = e.ch[1:0]; half = e.hf; #1; checks++;
      if ((e.d3 ? rd3 : rd) !== e.v) begin errors++; $display("FAIL %s ch%0d: rd=%h expected %h", e.nm, e.ch, e.d3 ? rd3 : rd, e.v); end
    end
    @(negedge clk); inhibit_we = 1'b1; inhibit_wd = 4'b0000;
    cyc(1);
    inhibit_we = 1'b0;
    cyc(1);
    event_inc = '0;
    checks++; if (inhibit !== 4'b0000) begin errors++; $display("FAIL uninhibit_mask: inhibit=%b expected 0000", inhibit); end
    push(0, 3, 0, 32'h11, "uninhibit_resume");
    while (q.size() > 0) begin
      e = q.pop_front(); @(negedge clk); sel = e.ch[1:0]; half = e.hf; #1; checks++;
      if ((e.d3 ? rd3 : rd) !== e.v) begin errors++; $display("FAIL %s ch%0d: rd=%h expected %h", e.nm, e.ch, e.d3 ? rd3 : rd, e.v); end
    end
  endtask

  task automatic test_write_priority;
    exp_t e;
    @(negedge clk);
    we = 1'b1; sel = 2'd0; half = 1'b0; wd = 32'h100; event_inc = 8'h03;
    #1;
    checks++; if (rd !== 32'd5) begin errors++; $display("FAIL read_during_write: rd=%h expected %h", rd, 32'd5); end
    cyc(1);
    we = 1'b0; event_inc = '0;
    push(0, 0, 0, 32'h100, "prio_lo");
    push(0, 0, 1, 32'h0, "prio_hi");
    while (q.size() > 0) begin
      e = q.pop_front(); @(negedge clk); sel = e.ch[1:0]; half = e.hf; #1; checks++;
      if ((e.d3 ? rd3 : rd) !== e.v) begin errors++; $display("FAIL %s ch%0d: rd=%h expected %h", e.nm, e.ch, e.d3 ? rd3 : rd, e.v); end
    end
  endtask

  task automatic test_out_of_range;
    exp_t e;
    @(negedge clk);
    we = 1'b1; sel = 2'd3; half = 1'b0; wd = 32'hDEAD;
    #1;
    checks++; if (rd3 !== 32'h0) begin errors++; $display("FAIL oor_read_now: rd=%h expected 0", rd3); end
    cyc(1);
    we = 1'b0;
    push(1, 3, 0, 32'h0, "oor_lo");
    push(1, 3, 1, 32'h0, "oor_hi");
    push(1, 0, 0, 32'h100, "oor_ch0");
    push(1, 1, 0, 32'h0, "oor_ch1");
    push(1, 2, 1, 32'h2, "oor_ch2_hi");
    push(0, 3, 0, 32'hDEAD, "inrange_ch3");
    while (q.size() > 0) begin
      e = q.pop_front(); @(negedge clk); sel = e.ch[1:0]; half = e.hf; #1; checks++;
      if ((e.d3 ? rd3 : rd) !== e.v) begin errors++; $display("FAIL %s ch%0d: rd=%h expected %h", e.nm, e.ch, e.d3 ? rd3 : rd, e.v); end
    end
    checks++; if (ovf3 !== 3'b0 || irq3 !== 1'b0) begin errors++; $display("FAIL oor_flags: ovf=%b irq=%b expected 000/0", ovf3, irq3); end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    sel = 2'd0; half = 1'b0; event_inc = '1;
    cyc(2);
    #2 reset = 1'b0;
    #1;
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL async_reset_rd: rd=%h expected 0", rd); end
    checks++; if (ovf !== 4'b0 || irq !== 1'b0) begin errors++; $display("FAIL async_reset_flags: ovf=%b irq=%b expected 0000/0", ovf, irq); end
    @(negedge clk); event_inc = '0; reset = 1'b1;
  endtask

  initial begin
    test_reset;
    test_split_write;
    test_wrap;
    test_set_beats_clear;
    test_inhibit;
    test_write_priority;
    test_out_of_range;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
